// File: rtl/cache_burst_pkg.sv
// Shared types and constants for the cache line burst responder.
package cache_burst_pkg;
  localparam int BEATS      = 4;
  localparam int LINE_OFF_W = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef logic [1:0] beat_idx_t;
endpackage

// File: rtl/rsp_skid_fifo.sv
// Two-entry response FIFO that decouples SRAM read returns from cache backpressure.
module rsp_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);
  logic [1:0][DATA_W-1:0] mem_q;
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop)
        rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/cache_burst_responder.sv
// Serves 4-beat cache line refills (critical word first, wrapping) and write-backs
// against a single-port synchronous SRAM, one request at a time.
module cache_burst_responder
  import cache_burst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int        BASE_W    = ADDR_W - LINE_OFF_W;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q;
  beat_idx_t           start_q;
  beat_idx_t           beat_q;
  beat_idx_t           ret_q;
  beat_idx_t           line_idx;
  logic                issue_done_q;
  logic                inflight_q;
  logic                wr_done_q;
  logic [ADDR_W-1:0]   beat_addr;
  logic                accept;
  logic                rd_issue;
  logic                wr_beat;
  logic                pop;
  logic [2:0]          occ;
  logic [1:0]          fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                unused_bits;

  // Sink for inputs/flags the datapath does not consume.
  assign unused_bits = ^{req_addr[1:0], fifo_full};

  assign accept    = req_valid & req_ready;
  assign line_idx  = start_q + beat_q;
  assign beat_addr = {base_q, line_idx, 2'b00};
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_last  = rsp_valid & (ret_q == LAST_BEAT);
  assign wr_done   = wr_done_q;
  // Occupancy the FIFO would have next cycle without a new issue; a pop frees a slot immediately.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  rsp_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (mem_rdata),
    .dout  (rsp_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_issue  = 1'b0;
    wr_beat   = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_write ? WRITE : READ;
      end
      READ: begin
        rd_issue = ~issue_done_q & (occ < 3'd2);
        mem_cs   = rd_issue;
        if (rd_issue) mem_addr = beat_addr;
        if (pop && ret_q == LAST_BEAT) state_d = IDLE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        wr_beat  = wr_valid;
        if (wr_valid) begin
          mem_cs    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = beat_addr;
          mem_wdata = wr_data;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      start_q      <= '0;
      beat_q       <= '0;
      ret_q        <= '0;
      issue_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      wr_done_q  <= wr_beat & (beat_q == LAST_BEAT);
      if (accept) begin
        base_q       <= req_addr[ADDR_W-1:LINE_OFF_W];
        start_q      <= req_addr[3:2];
        beat_q       <= '0;
        ret_q        <= '0;
        issue_done_q <= 1'b0;
      end else begin
        // Shared beat index: read issues and write beats never coexist.
        if (rd_issue || wr_beat) begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == LAST_BEAT) issue_done_q <= 1'b1;
        end
        if (pop) ret_q <= ret_q + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_cache_burst_responder.sv
// Randomized bench for cache_burst_responder with a line-level reference model.
module tb_cache_burst_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        wr_valid, wr_ready, wr_done;
  logic [31:0] wr_data;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_burst_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM environment: unwritten words read back as their own address.
  logic [31:0] sram [logic [31:0]];
  always @(posedge clk) begin
    if (mem_cs === 1'b1) begin
      if (mem_we === 1'b1) sram[mem_addr] = mem_wdata;
      else mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : mem_addr;
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  int          m_mode = 0;      // 0 idle, 1 read burst, 2 write burst
  logic [31:0] m_line;
  int          m_start, m_iss, m_ret, m_wb;
  bit          m_first, m_done_pend;
  logic [31:0] m_exp [4];
  logic [31:0] beat_data [4];
  int          beat_off [4];
  int          n_acc = 0, n_beats = 0, acc_cyc = 0;

  function automatic logic [31:0] line_addr(input int i);
    return m_line | (32'((m_start + i) & 3) << 2);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_last", rsp_last, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_wr_done", wr_done, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_mode = 0; m_done_pend = 0;
    end else begin
      chk("req_ready", req_ready, m_mode == 0);
      chk("wr_ready", wr_ready, m_mode == 2);
      chk("wr_done", wr_done, m_done_pend);
      m_done_pend = 0;
      case (m_mode)
        0: begin
          chk("idle_mem_cs", mem_cs, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
          if (req_valid) begin
            m_line  = req_addr & 32'hFFFF_FFF0;
            m_start = int'(req_addr[3:2]);
            m_mode  = req_write ? 2 : 1;
            m_iss = 0; m_ret = 0; m_wb = 0; m_first = 1;
            acc_cyc = cyc; n_acc++;
            for (int i = 0; i < 4; i++) m_exp[i] = ref_rd(line_addr(i));
          end
        end
        1: begin
          if (mem_cs) begin
            chk("rd_we", mem_we, 0);
            if (m_iss < 4) chk("rd_addr", mem_addr, line_addr(m_iss));
            else chk("rd_extra_issue", mem_cs, 0);
            m_iss++;
          end
          if (rsp_valid) begin
            if (m_first) chk("first_beat_latency", cyc - acc_cyc, 3);
            m_first = 0;
            chk("rsp_data", rsp_data, m_exp[m_ret]);
            chk("rsp_last", rsp_last, m_ret == 3);
            if (rsp_ready) begin
              beat_data[m_ret] = rsp_data;
              beat_off[m_ret]  = cyc - acc_cyc;
              m_ret++; n_beats++;
              if (m_ret == 4) m_mode = 0;
            end
          end else chk("rsp_last_nvalid", rsp_last, 0);
          // Issued-but-undelivered beats must fit FIFO + one SRAM read in flight.
          chk("outstanding_le2", (m_iss - m_ret) <= 2, 1);
        end
        default: begin
          chk("wr_rsp_valid", rsp_valid, 0);
          if (wr_valid) begin
            chk("wr_cs", mem_cs, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, line_addr(m_wb));
            chk("wr_wdata", mem_wdata, wr_data);
            ref_mem[line_addr(m_wb)] = wr_data;
            m_wb++;
            if (m_wb == 4) begin m_mode = 0; m_done_pend = 1; end
          end else chk("wr_cs_nvalid", mem_cs, 0);
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int prev);
    for (int i = 0; i < 50 && n_acc == prev; i++) step();
    chk("req_accept_timeout", n_acc != prev, 1);
  endtask

  task automatic issue_req(input logic wr, input logic [31:0] a);
    int prev;
    prev = n_acc;
    req_valid = 1'b1; req_write = wr; req_addr = a;
    wait_acc(prev);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && m_mode != 0; i++) step();
    chk("burst_timeout", m_mode == 0, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0][31:0] d, input int maxgap);
    issue_req(1'b1, a);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, maxgap)) step();
      wr_valid = 1'b1; wr_data = d[i];
      step();
      wr_valid = 1'b0;
    end
    wait_idle(20);
  endtask

  task automatic check_line(input string tag, input logic [3:0][31:0] e, input bit chk_off);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, beat_data[i], e[i]);
      if (chk_off) chk({tag, "_offset"}, beat_off[i], 3 + i);
    end
  endtask

  logic [3:0][31:0] ex, wd;
  logic [31:0]      ra;
  int               a0, prev;

  initial begin
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; wr_valid = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Aligned refill, full-rate return.
    issue_req(1'b0, 32'h100); wait_idle(40);
    ex[0] = 32'h100; ex[1] = 32'h104; ex[2] = 32'h108; ex[3] = 32'h10C;
    check_line("rd100", ex, 1);

    // Critical word in the middle of the line wraps to the line start.
    issue_req(1'b0, 32'h108); wait_idle(40);
    ex[0] = 32'h108; ex[1] = 32'h10C; ex[2] = 32'h100; ex[3] = 32'h104;
    check_line("rd108", ex, 1);

    // Cache stalls: only two reads may be outstanding.
    rdy_mode = 2;
    issue_req(1'b0, 32'h200);
    while (cyc < acc_cyc + 8) step();
    chk("stall_issue_count", m_iss, 2);
    rdy_mode = 0;
    wait_idle(40);
    ex[0] = 32'h200; ex[1] = 32'h204; ex[2] = 32'h208; ex[3] = 32'h20C;
    check_line("rd200", ex, 0);

    // Write-back starting mid-line, then read it back from the line start.
    wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003; wd[3] = 32'hDDDD_0004;
    do_write(32'h304, wd, 2);
    issue_req(1'b0, 32'h300); wait_idle(40);
    ex[0] = 32'hDDDD_0004; ex[1] = 32'hAAAA_0001; ex[2] = 32'hBBBB_0002; ex[3] = 32'hCCCC_0003;
    check_line("rd300", ex, 1);

    // Request held across a burst is taken the cycle the responder frees up.
    prev = n_acc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h180;
    wait_acc(prev);
    a0 = acc_cyc; req_addr = 32'h1C4;
    wait_acc(prev + 1);
    req_valid = 1'b0;
    chk("held_req_gap", acc_cyc - a0, 7);
    wait_idle(40);
    ex[0] = 32'h1C4; ex[1] = 32'h1C8; ex[2] = 32'h1CC; ex[3] = 32'h1C0;
    check_line("rd1c4", ex, 1);

    // Reset lands mid-read; the next read must not see a stale beat.
    issue_req(1'b0, 32'h140);
    prev = n_beats;
    for (int i = 0; i < 20 && n_beats == prev; i++) step();
    #2 rst = 1'b1;
    @(negedge clk); @(posedge clk);
    #1 rst = 1'b0;
    step();
    issue_req(1'b0, 32'h100); wait_idle(40);
    ex[0] = 32'h100; ex[1] = 32'h104; ex[2] = 32'h108; ex[3] = 32'h10C;
    check_line("rd100_post_rst", ex, 1);

    // Random traffic against the model.
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      ra = 32'h400 | ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        do_write(ra, wd, 3);
      end else begin
        issue_req(1'b0, ra);
        wait_idle(200);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    rdy_mode = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (vectors %0d)", vectors);
    $fatal(1, "watchdog expired");
  end
endmodule
